ddr_port_arbiter: RTL and testbench

//  Shares the single-word DDR controller command port between NUM_REQ requesters (camera writer, readout, self-test).

---
 rtl/ddr_arb_pkg.sv | 26 ++
 rtl/ddr_rr_select.sv | 39 +++
 rtl/ddr_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// ============================================================================
// Module   : ddr_arb_pkg
// Brief    : Shared types and widths for the DDR command-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_arb_pkg;

    localparam int DDR_BANK_W = 2;
    localparam int DDR_ADDR_W = 13;
    localparam int DDR_DATA_W = 16;

    localparam logic [DDR_DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ddr_rr_select.sv
// ============================================================================
// Module   : ddr_rr_select
// Brief    : Combinational round-robin pick starting at i_ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_rr_select #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PTR_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
// ============================================================================
// Module   : ddr_port_arbiter
// Brief    : Round-robin sharing of the DDR command port, one transaction in
//            flight. Optional WAIT timeout enabled by DDR_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         DDR_Ready,
    input  logic                         DDR_WrReady,
    input  logic                         DDR_RdReady,
    input  logic [DDR_DATA_W-1:0]        DDR_RdData,
    output logic                         DDR_WrStart,
    output logic                         DDR_RdStart,
    output logic [DDR_BANK_W-1:0]        DDR_WrBank,
    output logic [DDR_BANK_W-1:0]        DDR_RdBank,
    output logic [DDR_ADDR_W-1:0]        DDR_WrAddr,
    output logic [DDR_ADDR_W-1:0]        DDR_RdAddr,
    output logic [DDR_DATA_W-1:0]        DDR_WrData,
    input  logic [NUM_REQ-1:0]           Req_Valid,
    input  logic [NUM_REQ-1:0]           Req_Write,
    input  logic [DDR_BANK_W*NUM_REQ-1:0] Req_Bank,
    input  logic [DDR_ADDR_W*NUM_REQ-1:0] Req_Addr,
    input  logic [DDR_DATA_W*NUM_REQ-1:0] Req_WData,
    output logic [NUM_REQ-1:0]           Req_Ack,
    output logic [NUM_REQ-1:0]           Resp_Done,
    output logic [DDR_DATA_W-1:0]        Resp_RData,
    output logic                         Busy,
    output logic                         Err_Timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_win_idx;
    logic [NUM_REQ-1:0]      r_win_oh;
    logic                    r_is_write;
    logic [DDR_BANK_W-1:0]   r_cmd_bank;
    logic [DDR_ADDR_W-1:0]   r_cmd_addr;
    logic [DDR_DATA_W-1:0]   r_cmd_data;
    logic                    r_wr_q;
    logic                    r_rd_q;

    logic [NUM_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]        w_idx;
    logic                    w_any;
    logic                    w_done_edge;
    logic [PTR_W-1:0]        w_next_ptr;

    ddr_rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .i_valid (Req_Valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Only the edge of the type we issued counts as completion.
    assign w_done_edge = r_is_write ? (DDR_WrReady & ~r_wr_q)
                                    : (DDR_RdReady & ~r_rd_q);
    assign w_next_ptr  = (r_win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                            : r_win_idx + PTR_W'(1);
    assign Busy        = (r_state != IDLE);

`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_wait_cnt;
    logic        r_err_timeout;
    assign Err_Timeout = r_err_timeout;
`else
    assign Err_Timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_win_oh    <= '0;
            r_is_write  <= 1'b0;
            r_cmd_bank  <= '0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_wr_q      <= DDR_WrReady;
            r_rd_q      <= DDR_RdReady;
            DDR_WrStart <= 1'b0;
            DDR_RdStart <= 1'b0;
            DDR_WrBank  <= '0;
            DDR_RdBank  <= '0;
            DDR_WrAddr  <= '0;
            DDR_RdAddr  <= '0;
            DDR_WrData  <= '0;
            Req_Ack     <= '0;
            Resp_Done   <= '0;
            Resp_RData  <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_wr_q      <= DDR_WrReady;
            r_rd_q      <= DDR_RdReady;
            DDR_WrStart <= 1'b0;
            DDR_RdStart <= 1'b0;
            Req_Ack     <= '0;
            Resp_Done   <= '0;

            case (r_state)
                IDLE: begin
                    if (DDR_Ready && w_any) begin
                        r_win_idx  <= w_idx;
                        r_win_oh   <= w_grant;
                        Req_Ack    <= w_grant;
                        r_is_write <= Req_Write[w_idx];
                        r_cmd_bank <= Req_Bank[DDR_BANK_W*int'(w_idx) +: DDR_BANK_W];
                        r_cmd_addr <= Req_Addr[DDR_ADDR_W*int'(w_idx) +: DDR_ADDR_W];
                        r_cmd_data <= Req_WData[DDR_DATA_W*int'(w_idx) +: DDR_DATA_W];
                        r_state    <= GRANT;
                    end
                end

                GRANT: begin
                    if (r_is_write) begin
                        DDR_WrStart <= 1'b1;
                        DDR_WrBank  <= r_cmd_bank;
                        DDR_WrAddr  <= r_cmd_addr;
                        DDR_WrData  <= r_cmd_data;
                    end else begin
                        DDR_RdStart <= 1'b1;
                        DDR_RdBank  <= r_cmd_bank;
                        DDR_RdAddr  <= r_cmd_addr;
                    end
                    r_state <= ISSUE;
                end

                ISSUE: begin
`ifdef DDR_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= WAIT;
                end

                WAIT: begin
                    if (w_done_edge) begin
                        Resp_Done <= r_win_oh;
                        if (!r_is_write) begin
                            Resp_RData <= DDR_RdData;
                        end
                        r_state <= RESP;
                    end
`ifdef DDR_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == c_timeout_last) begin
                        Resp_Done     <= r_win_oh;
                        Resp_RData    <= TIMEOUT_DATA;
                        r_err_timeout <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
`endif
                end

                RESP: begin
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
// ============================================================================
// Module   : tb_ddr_port_arbiter
// Brief    : Directed self-checking bench for ddr_port_arbiter (2 ports).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TO_CYC  = 1024;

    logic                Clk = 1'b0;
    logic                Rst_n;
    logic                DDR_Ready, DDR_WrReady, DDR_RdReady;
    logic [15:0]         DDR_RdData;
    logic                DDR_WrStart, DDR_RdStart;
    logic [1:0]          DDR_WrBank, DDR_RdBank;
    logic [12:0]         DDR_WrAddr, DDR_RdAddr;
    logic [15:0]         DDR_WrData;
    logic [NUM_REQ-1:0]  Req_Valid, Req_Write, Req_Ack, Resp_Done;
    logic [2*NUM_REQ-1:0]  Req_Bank;
    logic [13*NUM_REQ-1:0] Req_Addr;
    logic [16*NUM_REQ-1:0] Req_WData;
    logic [15:0]         Resp_RData;
    logic                Busy, Err_Timeout;

    int n_checks = 0;
    int n_errors = 0;

    ddr_port_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .DDR_Ready(DDR_Ready),
        .DDR_WrReady(DDR_WrReady), .DDR_RdReady(DDR_RdReady), .DDR_RdData(DDR_RdData),
        .DDR_WrStart(DDR_WrStart), .DDR_RdStart(DDR_RdStart),
        .DDR_WrBank(DDR_WrBank), .DDR_RdBank(DDR_RdBank),
        .DDR_WrAddr(DDR_WrAddr), .DDR_RdAddr(DDR_RdAddr), .DDR_WrData(DDR_WrData),
        .Req_Valid(Req_Valid), .Req_Write(Req_Write), .Req_Bank(Req_Bank),
        .Req_Addr(Req_Addr), .Req_WData(Req_WData), .Req_Ack(Req_Ack),
        .Resp_Done(Resp_Done), .Resp_RData(Resp_RData), .Busy(Busy),
        .Err_Timeout(Err_Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic wr, input logic [1:0] bank,
                            input logic [12:0] addr, input logic [15:0] data);
        Req_Write[p]          = wr;
        Req_Bank[2*p +: 2]    = bank;
        Req_Addr[13*p +: 13]  = addr;
        Req_WData[16*p +: 16] = data;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_wrstart"}, 32'(DDR_WrStart), 32'h0);
        check_eq({tag, "_rdstart"}, 32'(DDR_RdStart), 32'h0);
        check_eq({tag, "_ack"},     32'(Req_Ack),     32'h0);
        check_eq({tag, "_done"},    32'(Resp_Done),   32'h0);
        check_eq({tag, "_busy"},    32'(Busy),        32'h0);
        check_eq({tag, "_rdata"},   32'(Resp_RData),  32'h0);
        check_eq({tag, "_wraddr"},  32'(DDR_WrAddr),  32'h0);
        check_eq({tag, "_err"},     32'(Err_Timeout), 32'h0);
    endtask

    initial begin
        Rst_n = 1'b0; DDR_Ready = 1'b0; DDR_WrReady = 1'b0; DDR_RdReady = 1'b0;
        DDR_RdData = '0; Req_Valid = '0; Req_Write = '0;
        Req_Bank = '0; Req_Addr = '0; Req_WData = '0;
        step(); step();
        check_idle_zero("reset");

        // 1: single write on port 0
        Rst_n = 1'b1; DDR_Ready = 1'b1;
        set_port(0, 1'b1, 2'd1, 13'h0155, 16'hBABE);
        Req_Valid = 2'b01;
        step();
        check_eq("t1_ack", 32'(Req_Ack), 32'h1);
        check_eq("t1_busy", 32'(Busy), 32'h1);
        Req_Valid = 2'b00;
        step();
        check_eq("t1_wrstart", 32'(DDR_WrStart), 32'h1);
        check_eq("t1_rdstart", 32'(DDR_RdStart), 32'h0);
        check_eq("t1_bank", 32'(DDR_WrBank), 32'h1);
        check_eq("t1_addr", 32'(DDR_WrAddr), 32'h0155);
        check_eq("t1_data", 32'(DDR_WrData), 32'hBABE);
        step();
        check_eq("t1_wrstart_off", 32'(DDR_WrStart), 32'h0);
        DDR_WrReady = 1'b1;
        step();
        check_eq("t1_done", 32'(Resp_Done), 32'h1);
        DDR_WrReady = 1'b0;
        step();
        check_eq("t1_done_off", 32'(Resp_Done), 32'h0);
        check_eq("t1_idle", 32'(Busy), 32'h0);

        // 2: read on port 1; a write edge during WAIT must be ignored
        set_port(1, 1'b0, 2'd0, 13'h0000, 16'h0000);
        Req_Valid = 2'b10;
        step();
        check_eq("t2_ack", 32'(Req_Ack), 32'h2);
        Req_Valid = 2'b00;
        step();
        check_eq("t2_rdstart", 32'(DDR_RdStart), 32'h1);
        check_eq("t2_wrstart", 32'(DDR_WrStart), 32'h0);
        check_eq("t2_rdaddr", 32'(DDR_RdAddr), 32'h0);
        check_eq("t2_wrdata_hold", 32'(DDR_WrData), 32'hBABE);
        step();
        DDR_WrReady = 1'b1;
        step();
        check_eq("t2_wrong_edge", 32'(Resp_Done), 32'h0);
        DDR_RdData = 16'hBABE; DDR_RdReady = 1'b1;
        step();
        check_eq("t2_done", 32'(Resp_Done), 32'h2);
        check_eq("t2_rdata", 32'(Resp_RData), 32'hBABE);
        DDR_WrReady = 1'b0; DDR_RdReady = 1'b0;
        step();

        // 3: both ports continuously valid from reset -> 0,1,0,1
        Rst_n = 1'b0;
        set_port(0, 1'b1, 2'd0, 13'h0010, 16'h1111);
        set_port(1, 1'b1, 2'd2, 13'h0020, 16'h2222);
        Req_Valid = 2'b11;
        step();
        Rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check_eq("t3_ack", 32'(Req_Ack), (t % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check_eq("t3_addr", 32'(DDR_WrAddr), (t % 2 == 0) ? 32'h10 : 32'h20);
            step();
            DDR_WrReady = 1'b1;
            step();
            check_eq("t3_done", 32'(Resp_Done), (t % 2 == 0) ? 32'h1 : 32'h2);
            DDR_WrReady = 1'b0;
            step();
        end
        Req_Valid = 2'b00;

        // 4: no grant while DDR_Ready is low
        DDR_Ready = 1'b0;
        set_port(0, 1'b1, 2'd3, 13'h00AA, 16'h5A5A);
        Req_Valid = 2'b01;
        for (int t = 0; t < 3; t++) begin
            step();
            check_eq("t4_noack", 32'(Req_Ack), 32'h0);
            check_eq("t4_nostart", 32'(DDR_WrStart), 32'h0);
        end
        DDR_Ready = 1'b1;
        step();
        check_eq("t4_ack", 32'(Req_Ack), 32'h1);
        Req_Valid = 2'b00;
        step(); step();
        DDR_WrReady = 1'b1;
        step();
        check_eq("t4_done", 32'(Resp_Done), 32'h1);
        DDR_WrReady = 1'b0;
        step();

        // 5: reset during WAIT of a port-1 write drops it; pointer back to 0
        set_port(1, 1'b1, 2'd1, 13'h1FFF, 16'h1234);
        Req_Valid = 2'b10;
        step();
        check_eq("t5_ack", 32'(Req_Ack), 32'h2);
        Req_Valid = 2'b00;
        step();
        check_eq("t5_addr", 32'(DDR_WrAddr), 32'h1FFF);
        step();
        Rst_n = 1'b0;
        step();
        check_idle_zero("t5_rst");
        Rst_n = 1'b1; DDR_WrReady = 1'b1;
        step();
        check_eq("t5_nodone", 32'(Resp_Done), 32'h0);
        check_eq("t5_notbusy", 32'(Busy), 32'h0);
        DDR_WrReady = 1'b0;
        Req_Write = 2'b11; Req_Valid = 2'b11;
        step();
        check_eq("t5_ptr0", 32'(Req_Ack), 32'h1);
        Req_Valid = 2'b00;
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;

`ifdef DDR_ARB_TIMEOUT_EN
        // 6: read never completes -> timeout abort
        begin
            int n;
            bit seen;
            set_port(0, 1'b0, 2'd0, 13'h0001, 16'h0000);
            Req_Valid = 2'b01;
            step();
            Req_Valid = 2'b00;
            step(); step();
            n = 0; seen = 1'b0;
            while (!seen && n < TO_CYC + 50) begin
                step();
                n++;
                if (Resp_Done != 2'b00) seen = 1'b1;
            end
            check_eq("t6_seen", 32'(seen), 32'h1);
            check_eq("t6_cycles", 32'(n), 32'(TO_CYC));
            check_eq("t6_done", 32'(Resp_Done), 32'h1);
            check_eq("t6_rdata", 32'(Resp_RData), 32'hDEAD);
            check_eq("t6_err", 32'(Err_Timeout), 32'h1);
            step();
            check_eq("t6_err_sticky", 32'(Err_Timeout), 32'h1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
